// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer. One full_adder handles one bit pair per clock,
// LSB first. A registered carry links the bits, and a shift register collects the result.
// start/busy/done handshake with the core control.

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;
  logic             w_s;
  logic             w_c;

  // The only adder in the datapath: one bit pair plus the registered carry
  full_adder u_fa (
    .i_a (r_opa[0]),
    .i_b (r_opb[0]),
    .i_c (r_carry),
    .o_s (w_s),
    .o_c (w_c)
  );

  // Sequencer: accept in IDLE/DONE, shift one bit per RUN edge, flag at the last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_opa   <= '0;
      r_opb   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            // Subtraction: invert B and inject a carry of 1 (two's complement)
            r_opa   <= a;
            r_opb   <= sub ? ~b : b;
            r_carry <= sub;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_sum   <= {w_s, r_sum[WIDTH-1:1]};
          r_opa   <= {1'b0, r_opa[WIDTH-1:1]};
          r_opb   <= {1'b0, r_opb[WIDTH-1:1]};
          r_carry <= w_c;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            // r_carry holds the carry into the MSB at this edge
            r_cout  <= w_c;
            r_ovf   <= w_c ^ r_carry;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8. It runs directed vectors,
// start-ignore and back-to-back cases, an async abort, and random ops checked against an
// arithmetic model.

module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int n_tests = 0;
  int n_fail  = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views
  function automatic void ref_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                 output logic [W-1:0] rs, output logic rc, output logic ro);
    int u;
    int sr;
    int sx;
    int sy;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      u  = int'(x) - int'(y);
      rc = (x >= y);
      sr = sx - sy;
    end else begin
      u  = int'(x) + int'(y);
      rc = (u > 255);
      sr = sx + sy;
    end
    rs = u[W-1:0];
    ro = (sr > 127) || (sr < -128);
  endfunction

  // Call at a negedge with the DUT in IDLE or DONE; returns at the negedge where done is expected
  task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic si,
                       input bit inject);
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
    ref_op(ai, bi, si, es, ec, eo);
    start = 1'b1; a = ai; b = bi; sub = si;
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      chk("busy_run", busy, 1);
      chk("done_early", done, 0);
      if (inject && k == 2) start = 1'b1;
      if (inject && k == 3) start = 1'b0;
    end
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("busy_in_done", busy, 0);
    chk("sum", sum, 32'(es));
    chk("cout", cout, 32'(ec));
    chk("overflow", overflow, 32'(eo));
  endtask

  // Single op followed by one idle cycle where done must drop and results hold
  task automatic op_idle(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic si);
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
    ref_op(ai, bi, si, es, ec, eo);
    do_op(ai, bi, si, 1'b0);
    @(negedge clk);
    chk("done_drop", done, 0);
    chk("busy_idle", busy, 0);
    chk("sum_hold", sum, 32'(es));
    chk("cout_hold", cout, 32'(ec));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", overflow, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // Directed vectors
    op_idle(8'h3C, 8'h05, 1'b0);
    op_idle(8'h7F, 8'h01, 1'b0);
    op_idle(8'hFF, 8'h01, 1'b0);
    op_idle(8'h05, 8'h07, 1'b1);
    op_idle(8'h80, 8'h01, 1'b1);

    // Start pulsed mid-run is ignored; start held in DONE chains the next op
    do_op(8'h12, 8'h34, 1'b0, 1'b1);
    do_op(8'h55, 8'hAA, 1'b1, 1'b0);
    @(negedge clk);
    chk("b2b_done_drop", done, 0);

    // Async abort after edge 4
    start = 1'b1; a = 8'h11; b = 8'h22; sub = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    chk("abort_ovf", overflow, 0);
    for (int k = 0; k < W + 2; k++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    op_idle(8'hC8, 8'h64, 1'b0);

    // Random ops, mixing back-to-back and idle gaps
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rs;
      ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
      do_op(ra, rb, rs, 1'b0);
      if ($urandom_range(0, 1) == 0) begin
        @(negedge clk);
        chk("rnd_done_drop", done, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
